// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg: shared types and constants for the load/store unit controller.
//   lsu_state_e         - controller state encoding (3 bits)
//   axi4_resp_t         - AXI4 xRESP field type
//   AXI4_RESP_OKAY      - the only response treated as success
//   LSU_TIMEOUT_DEFAULT - default watchdog limit in cycles
//   resp_is_err()       - true for any response other than OKAY
package lsu_ctrl_pkg;

  typedef enum logic [2:0] {
    LSU_STATE_IDLE    = 3'd0,
    LSU_STATE_RD_ADDR = 3'd1,
    LSU_STATE_RD_DATA = 3'd2,
    LSU_STATE_WR_REQ  = 3'd3,
    LSU_STATE_WR_RESP = 3'd4,
    LSU_STATE_DONE    = 3'd5
  } lsu_state_e;

  typedef logic [1:0] axi4_resp_t;

  localparam axi4_resp_t  AXI4_RESP_OKAY      = 2'b00;
  localparam int unsigned LSU_TIMEOUT_DEFAULT = 1024;

  function automatic logic resp_is_err(input axi4_resp_t resp);
    return resp != AXI4_RESP_OKAY;
  endfunction

endpackage

// File: rtl/lsu_watchdog.sv
// lsu_watchdog: per-instruction cycle counter for the LSU controller.
//   clock, reset : system clock, asynchronous active-high reset
//   clear        : hold the count at zero (controller idle)
//   count_en     : controller is waiting on the bus this cycle
//   expired      : count has reached TIMEOUT_CYCLES-1 while counting
module lsu_watchdog
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [31:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (count_en) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign expired = count_en && (count_q == 32'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: sequences the AXI4 handshakes for one load or store at a time
// and hands the result to WBU over valid/ready.
//   clock, reset            : system clock, asynchronous active-high reset
//   valid_i/ready_o         : instruction handshake from execute
//   is_load_i, is_store_i   : instruction class (load wins if both set)
//   valid_o/ready_i         : result handshake to WBU
//   rdata_we_o              : capture strobe for the LSU datapath read register
//   err_o                   : sticky access error until the WBU handshake
//   aw*/w*/b*/ar*/r*        : AXI4 channel control (single beat, arlen=0)
// Build option: define LSU_TIMEOUT_EN to enable the TIMEOUT_CYCLES watchdog,
// which forces DONE with err_o set when the slave stalls too long.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic       is_load_i,
  input  logic       is_store_i,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       rdata_we_o,
  output logic       err_o,
  output logic       awvalid_o,
  input  logic       awready_i,
  output logic       wvalid_o,
  input  logic       wready_i,
  input  logic       bvalid_i,
  output logic       bready_o,
  input  logic [1:0] bresp_i,
  output logic       arvalid_o,
  input  logic       arready_i,
  input  logic       rvalid_i,
  output logic       rready_o,
  input  logic [1:0] rresp_i,
  input  logic       rlast_i
);

  lsu_state_e state_q, state_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic       err_q, err_d;
  logic       timeout;

`ifdef LSU_TIMEOUT_EN
  logic busy;
  assign busy = (state_q == LSU_STATE_RD_ADDR) || (state_q == LSU_STATE_RD_DATA) ||
                (state_q == LSU_STATE_WR_REQ)  || (state_q == LSU_STATE_WR_RESP);

  // Holding the count clear while idle means it starts from zero on the
  // first bus-waiting cycle of every instruction.
  lsu_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (state_q == LSU_STATE_IDLE),
    .count_en(busy),
    .expired (timeout)
  );
`else
  logic unused_timeout_cfg;
  assign timeout            = 1'b0;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= LSU_STATE_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    // NOTE: every value written below gets a hold default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;

    case (state_q)
      LSU_STATE_IDLE: begin
        if (valid_i) begin
          if (is_load_i)       state_d = LSU_STATE_RD_ADDR;
          else if (is_store_i) state_d = LSU_STATE_WR_REQ;
          else                 state_d = LSU_STATE_DONE;
        end
      end
      LSU_STATE_RD_ADDR: begin
        if (arready_i) state_d = LSU_STATE_RD_DATA;
      end
      LSU_STATE_RD_DATA: begin
        if (rvalid_i) begin
          if (resp_is_err(rresp_i)) err_d = 1'b1;
          if (rlast_i) state_d = LSU_STATE_DONE;
        end
      end
      LSU_STATE_WR_REQ: begin
        // A ready seen after the matching valid has dropped only re-sets an
        // already-set flag, so it is harmless.
        if (awready_i) aw_done_d = 1'b1;
        if (wready_i)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          state_d   = LSU_STATE_WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      LSU_STATE_WR_RESP: begin
        if (bvalid_i) begin
          if (resp_is_err(bresp_i)) err_d = 1'b1;
          state_d = LSU_STATE_DONE;
        end
      end
      LSU_STATE_DONE: begin
        if (ready_i) begin
          state_d = LSU_STATE_IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = LSU_STATE_IDLE;
    endcase

    // Watchdog expiry abandons the bus transaction; valids drop next cycle.
    if (timeout) begin
      state_d   = LSU_STATE_DONE;
      err_d     = 1'b1;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end
  end

  // All handshake outputs decode registered state only; rdata_we_o alone
  // follows rvalid_i so the datapath captures on the R handshake edge.
  assign ready_o    = (state_q == LSU_STATE_IDLE);
  assign valid_o    = (state_q == LSU_STATE_DONE);
  assign arvalid_o  = (state_q == LSU_STATE_RD_ADDR);
  assign rready_o   = (state_q == LSU_STATE_RD_DATA);
  assign rdata_we_o = (state_q == LSU_STATE_RD_DATA) && rvalid_i;
  assign awvalid_o  = (state_q == LSU_STATE_WR_REQ) && !aw_done_q;
  assign wvalid_o   = (state_q == LSU_STATE_WR_REQ) && !w_done_q;
  assign bready_o   = (state_q == LSU_STATE_WR_RESP);
  assign err_o      = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: self-checking bench for lsu_ctrl. A cycle-stepping slave/WBU
// responder applies per-transaction wait counts; expected latency, error and
// handshake counts come from a transaction-level model of the controller.
// Define LSU_TIMEOUT_EN for the bench and the RTL together to add the
// watchdog case (TIMEOUT_CYCLES=16).
module tb_lsu_ctrl;

  localparam int BUDGET = 200;
  localparam int TMO    = 16;

  logic       clock, reset;
  logic       valid_i, ready_o, is_load_i, is_store_i;
  logic       valid_o, ready_i, rdata_we_o, err_o;
  logic       awvalid_o, awready_i, wvalid_o, wready_i;
  logic       bvalid_i, bready_o;
  logic [1:0] bresp_i;
  logic       arvalid_o, arready_i, rvalid_i, rready_o, rlast_i;
  logic [1:0] rresp_i;

  lsu_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .valid_i(valid_i), .ready_o(ready_o),
    .is_load_i(is_load_i), .is_store_i(is_store_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .rdata_we_o(rdata_we_o), .err_o(err_o),
    .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i),
    .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rvalid_i(rvalid_i), .rready_o(rready_o), .rresp_i(rresp_i), .rlast_i(rlast_i)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One instruction plus slave/WBU behaviour: *_d = cycles the channel
  // waits with its valid/ready pending before the other side responds.
  typedef struct packed {
    bit         is_load;
    bit         is_store;
    int         ar_d, r_d, aw_d, w_d, b_d, wbu_d;
    logic [1:0] resp;
    int         exp_lat;
    bit         exp_err;
  } vec_t;

  typedef struct packed {
    bit ready_at_issue, timed_out, unstable, order_bad, axi_active, err;
    int lat, n_we, n_ar, n_aw, n_w, n_b;
  } res_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint actual, input longint expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(input bit ld, input bit st, input int ar_d, input int r_d,
                              input int aw_d, input int w_d, input int b_d, input int wbu_d,
                              input logic [1:0] resp, input int exp_lat, input bit exp_err);
    vec_t v;
    v.is_load = ld; v.is_store = st;
    v.ar_d = ar_d; v.r_d = r_d; v.aw_d = aw_d; v.w_d = w_d; v.b_d = b_d; v.wbu_d = wbu_d;
    v.resp = resp; v.exp_lat = exp_lat; v.exp_err = exp_err;
    return v;
  endfunction

  // Transaction-level model: every bus phase costs one cycle plus its wait,
  // AW and W overlap, DONE follows one cycle after the last phase.
  function automatic void model(input vec_t v, output int lat, output bit err);
    if (v.is_load) begin
      lat = 3 + v.ar_d + v.r_d;
      err = (v.resp != 2'b00);
    end else if (v.is_store) begin
      lat = 3 + ((v.aw_d > v.w_d) ? v.aw_d : v.w_d) + v.b_d;
      err = (v.resp != 2'b00);
    end else begin
      lat = 1;
      err = 1'b0;
    end
  endfunction

  task automatic clear_slave();
    arready_i = 0; rvalid_i = 0; rresp_i = 0; rlast_i = 0;
    awready_i = 0; wready_i = 0; bvalid_i = 0; bresp_i = 0; ready_i = 0;
  endtask

  // Called just after a rising edge with the controller idle; returns just
  // after the edge that completes the WBU handshake.
  task automatic run_txn(input vec_t v, output res_t r);
    int  arc, rc, awc, wc, bc, wbc;
    bit  got;
    arc = 0; rc = 0; awc = 0; wc = 0; bc = 0; wbc = 0; got = 0;
    r = '0;
    valid_i = 1; is_load_i = v.is_load; is_store_i = v.is_store;
    @(negedge clock);
    r.ready_at_issue = ready_o;
    @(posedge clock); #1;
    valid_i = 0; is_load_i = 0; is_store_i = 0;
    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      arready_i = arvalid_o && (arc == v.ar_d); if (arvalid_o) arc++;
      rvalid_i  = rready_o  && (rc  == v.r_d);  if (rready_o)  rc++;
      rresp_i   = v.resp; rlast_i = 1'b1;
      awready_i = awvalid_o && (awc == v.aw_d); if (awvalid_o) awc++;
      wready_i  = wvalid_o  && (wc  == v.w_d);  if (wvalid_o)  wc++;
      bvalid_i  = bready_o  && (bc  == v.b_d);  if (bready_o)  bc++;
      bresp_i   = v.resp;
      if (valid_o) begin
        if (r.lat == 0) begin r.lat = cyc; r.err = err_o; end
        if (err_o != r.err) r.unstable = 1;
        ready_i = (wbc == v.wbu_d); wbc++;
      end else begin
        ready_i = 0;
        if (r.lat != 0) r.unstable = 1;
      end
      if (arvalid_o || awvalid_o || wvalid_o || rready_o || bready_o) r.axi_active = 1;
      if (bready_o && r.n_w == 0) r.order_bad = 1;
      @(negedge clock);
      if (rdata_we_o)             r.n_we++;
      if (arvalid_o && arready_i) r.n_ar++;
      if (awvalid_o && awready_i) r.n_aw++;
      if (wvalid_o && wready_i)   r.n_w++;
      if (bready_o && bvalid_i)   r.n_b++;
      got = valid_o && ready_i;
      @(posedge clock); #1;
      if (got) break;
    end
    clear_slave();
    if (!got) r.timed_out = 1;
  endtask

  task automatic check_txn(input string tag, input vec_t v, input res_t r,
                           input int exp_lat, input bit exp_err);
    bit ld, st;
    ld = v.is_load;
    st = v.is_store && !v.is_load;
    check({tag, "_ready_at_issue"}, r.ready_at_issue, 1);
    check({tag, "_completed"},      r.timed_out, 0);
    check({tag, "_latency"},        r.lat, exp_lat);
    check({tag, "_err"},            r.err, exp_err);
    check({tag, "_rdata_we_pulses"}, r.n_we, ld ? 1 : 0);
    check({tag, "_ar_hs"},          r.n_ar, ld ? 1 : 0);
    check({tag, "_aw_hs"},          r.n_aw, st ? 1 : 0);
    check({tag, "_w_hs"},           r.n_w,  st ? 1 : 0);
    check({tag, "_b_hs"},           r.n_b,  st ? 1 : 0);
    check({tag, "_held_in_done"},   r.unstable, 0);
    check({tag, "_b_after_w"},      r.order_bad, 0);
    if (!ld && !st) check({tag, "_no_axi"}, r.axi_active, 0);
    check({tag, "_post_ready"}, ready_o, 1);
    check({tag, "_post_valid"}, valid_o, 0);
    check({tag, "_post_err"},   err_o, 0);
  endtask

  vec_t vecs [9];
  vec_t v;
  res_t r;
  int   lat;
  bit   err;

  initial begin
    #20000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    valid_i = 0; is_load_i = 0; is_store_i = 0;
    clear_slave();
    reset = 1;

    //                ld st ar r aw w b wbu resp    lat err
    vecs[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3, 0);  // LW zero-wait
    vecs[1] = mk(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3, 0);  // SW zero-wait
    vecs[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0);  // non-memory
    vecs[3] = mk(1, 1, 1, 0, 0, 0, 0, 0, 2'b01, 4, 1);  // both set: load wins
    vecs[4] = mk(0, 1, 0, 0, 0, 4, 0, 0, 2'b00, 7, 0);  // W late by 4
    vecs[5] = mk(0, 1, 0, 0, 0, 0, 0, 5, 2'b10, 3, 1);  // SB SLVERR, WBU stall 5
    vecs[6] = mk(1, 0, 2, 3, 0, 0, 0, 2, 2'b11, 8, 1);  // LW waits, DECERR
    vecs[7] = mk(0, 1, 0, 0, 3, 1, 2, 1, 2'b00, 8, 0);  // AW late, B late
    vecs[8] = mk(0, 0, 0, 0, 0, 0, 0, 3, 2'b00, 1, 0);  // non-memory, WBU stall

    repeat (3) @(posedge clock);
    #1;
    check("reset_ready",   ready_o, 1);
    check("reset_valid",   valid_o, 0);
    check("reset_err",     err_o, 0);
    check("reset_axi_any", {arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, rdata_we_o}, 0);
    reset = 0;
    @(posedge clock); #1;

    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i], r);
      check_txn($sformatf("vec%0d", i), vecs[i], r, vecs[i].exp_lat, vecs[i].exp_err);
    end

    // SW with W accepted 4 cycles after AW: AW drops, W holds, B waits for W.
    valid_i = 1; is_store_i = 1;
    @(posedge clock); #1;
    valid_i = 0; is_store_i = 0;
    check("sw_c1_awvalid", awvalid_o, 1);
    check("sw_c1_wvalid",  wvalid_o, 1);
    awready_i = 1;
    @(posedge clock); #1;
    awready_i = 0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("sw_c%0d_awvalid", k + 2), awvalid_o, 0);
      check($sformatf("sw_c%0d_wvalid", k + 2),  wvalid_o, 1);
      check($sformatf("sw_c%0d_bready", k + 2),  bready_o, 0);
      wready_i = (k == 3);
      @(posedge clock); #1;
    end
    wready_i = 0;
    check("sw_c6_bready", bready_o, 1);
    check("sw_c6_wvalid", wvalid_o, 0);
    bvalid_i = 1; bresp_i = 2'b00;
    @(posedge clock); #1;
    bvalid_i = 0;
    check("sw_c7_valid", valid_o, 1);
    check("sw_c7_err",   err_o, 0);
    ready_i = 1;
    @(posedge clock); #1;
    ready_i = 0;
    check("sw_post_ready", ready_o, 1);

    // Reset in RD_DATA with rvalid low, then a clean load.
    valid_i = 1; is_load_i = 1;
    @(posedge clock); #1;
    valid_i = 0; is_load_i = 0;
    arready_i = 1;
    @(posedge clock); #1;
    arready_i = 0;
    check("rst_in_rd_data", rready_o, 1);
    #2;
    reset = 1;
    #1;
    check("rst_ready",   ready_o, 1);
    check("rst_rready",  rready_o, 0);
    check("rst_arvalid", arvalid_o, 0);
    check("rst_valid",   valid_o, 0);
    check("rst_we",      rdata_we_o, 0);
    @(posedge clock); #1;
    reset = 0;
    @(posedge clock); #1;
    run_txn(vecs[0], r);
    check_txn("post_rst_lw", vecs[0], r, 3, 0);

`ifdef LSU_TIMEOUT_EN
    // arready never comes: arvalid held 16 cycles, then DONE with err.
    v = mk(1, 0, 100000, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    run_txn(v, r);
    check("tmo_completed", r.timed_out, 0);
    check("tmo_latency",   r.lat, TMO + 1);
    check("tmo_err",       r.err, 1);
    check("tmo_ar_hs",     r.n_ar, 0);
    check("tmo_we",        r.n_we, 0);
    check("tmo_post_err",  err_o, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       begin v.is_load = 1; v.is_store = 0; end
        1:       begin v.is_load = 0; v.is_store = 1; end
        2:       begin v.is_load = 0; v.is_store = 0; end
        default: begin v.is_load = 1; v.is_store = 1; end
      endcase
      v.ar_d  = int'($urandom_range(0, 4));
      v.r_d   = int'($urandom_range(0, 4));
      v.aw_d  = int'($urandom_range(0, 4));
      v.w_d   = int'($urandom_range(0, 4));
      v.b_d   = int'($urandom_range(0, 4));
      v.wbu_d = int'($urandom_range(0, 3));
      v.resp  = 2'($urandom_range(0, 3));
      model(v, lat, err);
      run_txn(v, r);
      check_txn($sformatf("rnd%0d", i), v, r, lat, err);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
